// File: rtl/vpu_sram_stream_if.sv
// ---------------------------------------------------------------------------
// vpu_sram_stream_if
// Bundles every handshake and bus signal of the VPU <-> SRAM stream engine.
//
// Signal groups:
//   cmd_*        command handshake (valid/ready, store flag, address, length)
//   rd_*         load data stream towards the VPU (valid/ready/data)
//   wr_*         store data stream from the VPU (valid/ready/data)
//   sram_*       SRAM request port (addr/re/we/wdata/ready) and read return
//                (rdata/rvalid)
//   busy, done   engine status
//
// Modports:
//   slave   the stream engine itself
//   master  the surrounding environment, i.e. the VPU and the SRAM together
// ---------------------------------------------------------------------------
interface vpu_sram_stream_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 20,
  parameter int LEN_W  = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_is_store;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;

  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  logic [ADDR_W-1:0] sram_addr;
  logic              sram_re;
  logic              sram_we;
  logic [DATA_W-1:0] sram_wdata;
  logic              sram_ready;
  logic [DATA_W-1:0] sram_rdata;
  logic              sram_rvalid;

  logic              busy;
  logic              done;

  modport slave (
    input  cmd_valid, cmd_is_store, cmd_addr, cmd_len,
    input  rd_ready, wr_data, wr_valid,
    input  sram_ready, sram_rdata, sram_rvalid,
    output cmd_ready, rd_data, rd_valid, wr_ready,
    output sram_addr, sram_re, sram_we, sram_wdata,
    output busy, done
  );

  modport master (
    output cmd_valid, cmd_is_store, cmd_addr, cmd_len,
    output rd_ready, wr_data, wr_valid,
    output sram_ready, sram_rdata, sram_rvalid,
    input  cmd_ready, rd_data, rd_valid, wr_ready,
    input  sram_addr, sram_re, sram_we, sram_wdata,
    input  busy, done
  );
endinterface

// File: rtl/vpu_sram_stream.sv
// ---------------------------------------------------------------------------
// vpu_sram_stream
// Moves bursts of words between a VPU and a single-port SRAM.
//   Load : reads SRAM words starting at cmd_addr and streams them to the VPU
//          through a small return buffer. Reads are only issued while there
//          is guaranteed room in that buffer for their return data.
//   Store: passes VPU words straight through to SRAM writes, no buffering.
//
// Ports:
//   clk  single clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  vpu_sram_stream_if.slave: command, load stream, store stream,
//        SRAM request/return and busy/done status
// ---------------------------------------------------------------------------
module vpu_sram_stream #(
  parameter int DATA_W     = 256,
  parameter int ADDR_W     = 20,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  vpu_sram_stream_if.slave    bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STORE,
    DRAIN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [LEN_W-1:0]  remaining;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  fifo_count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic              done_r;

  logic              has_work;
  logic [CNT_W:0]    credit_used;
  logic              credit_ok;
  logic              rd_issue;
  logic              rd_accept;
  logic              ret_push;
  logic              fifo_pop;
  logic              wr_accept;
  logic [CNT_W-1:0]  outstanding_nxt;
  logic [CNT_W-1:0]  fifo_count_nxt;

  // Every issued read reserves a buffer slot until its data is popped, so
  // reads in flight plus buffered words may never exceed the buffer depth.
  // Returns arriving with nothing outstanding are stale (e.g. after a reset)
  // and are dropped.
  always_comb begin
    has_work        = (remaining != '0);
    credit_used     = {1'b0, outstanding} + {1'b0, fifo_count};
    credit_ok       = (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    rd_issue        = (state == LOAD) && has_work && credit_ok;
    rd_accept       = rd_issue && bus.sram_ready;
    ret_push        = bus.sram_rvalid && (outstanding != '0);
    fifo_pop        = (fifo_count != '0) && bus.rd_ready;
    wr_accept       = (state == STORE) && has_work && bus.wr_valid && bus.sram_ready;
    outstanding_nxt = outstanding + CNT_W'(rd_accept) - CNT_W'(ret_push);
    fifo_count_nxt  = fifo_count + CNT_W'(ret_push) - CNT_W'(fifo_pop);
  end

  assign bus.cmd_ready  = (state == IDLE);
  assign bus.sram_addr  = ptr;
  assign bus.sram_re    = rd_issue;
  assign bus.sram_we    = (state == STORE) && has_work && bus.wr_valid;
  assign bus.sram_wdata = bus.wr_data;
  assign bus.wr_ready   = (state == STORE) && has_work && bus.sram_ready;
  assign bus.rd_valid   = (fifo_count != '0);
  assign bus.rd_data    = mem[rd_ptr];
  assign bus.done       = done_r;
  assign bus.busy       = (state != IDLE) || done_r;

  // Control state machine plus counters. DRAIN finishes on the edge where
  // the final word leaves the buffer, so done shows up in the very next
  // cycle; a zero-length command never leaves IDLE and only pulses done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      remaining   <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      done_r      <= 1'b0;
    end else begin
      done_r      <= 1'b0;
      outstanding <= outstanding_nxt;
      fifo_count  <= fifo_count_nxt;
      if (ret_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            ptr       <= bus.cmd_addr;
            remaining <= bus.cmd_len;
            if (bus.cmd_len == '0) begin
              done_r <= 1'b1;
            end else if (bus.cmd_is_store) begin
              state <= STORE;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (rd_accept) begin
            ptr       <= ptr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if ((outstanding_nxt == '0) && (fifo_count_nxt == '0)) begin
            state  <= IDLE;
            done_r <= 1'b1;
          end
        end
        STORE: begin
          if (wr_accept) begin
            ptr       <= ptr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state  <= IDLE;
              done_r <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return buffer storage; data needs no reset because occupancy is tracked
  // by the counters above.
  always_ff @(posedge clk) begin
    if (ret_push) begin
      mem[wr_ptr] <= bus.sram_rdata;
    end
  end

endmodule

// File: tb/tb_vpu_sram_stream.sv
// ---------------------------------------------------------------------------
// tb_vpu_sram_stream
// Self-checking bench for vpu_sram_stream. A behavioural SRAM (sparse
// memory plus an in-order return queue with per-read latency) and a
// VPU-side driver surround the design; expected addresses and data are
// derived from the command (start address + i, modulo 2^20) and the
// bench's own memory contents.
// ---------------------------------------------------------------------------
module tb_vpu_sram_stream;
  localparam int DW    = 256;
  localparam int AW    = 20;
  localparam int LW    = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  vpu_sram_stream_if #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) bus ();

  vpu_sram_stream #(
    .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -10;
  int cmd_cyc = -10;
  int last_xfer_cyc = -10;
  int rd_acc = 0;
  int act_cnt = 0;
  int inflight = 0;
  int last_due = 0;
  int done_base = 0;
  int rd_base = 0;

  int ready_mode = 0;
  int rdr_mode = 1;
  int wv_mode = 1;
  int lat_fixed = 1;

  logic [DW-1:0] sram_mem [int];
  logic [AW-1:0] exp_rd_addr [$];
  logic [DW-1:0] exp_rd_data [$];
  logic [AW-1:0] exp_wr_addr [$];
  logic [DW-1:0] exp_wr_data [$];
  logic [DW-1:0] st_q [$];
  logic [DW-1:0] ret_data [$];
  int            ret_due [$];

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    logic [31:0] h;
    if (sram_mem.exists(int'(a))) begin
      return sram_mem[int'(a)];
    end
    h = {12'h0, a} * 32'h9E37_79B1;
    return {4{h, ~h}};
  endfunction

  // Environment driver: one step after each rising edge it sets SRAM
  // readiness, VPU read readiness, the next store word and any read return
  // whose latency has expired.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.sram_ready = 1'b1;
      1:       bus.sram_ready = ($urandom_range(99) < 65);
      default: bus.sram_ready = ~bus.sram_ready;
    endcase
    case (rdr_mode)
      0:       bus.rd_ready = 1'b0;
      1:       bus.rd_ready = 1'b1;
      default: bus.rd_ready = ($urandom_range(1) == 1);
    endcase
    if (st_q.size() != 0) begin
      bus.wr_valid = (wv_mode == 1) ? 1'b1 : ($urandom_range(3) != 0);
      bus.wr_data  = st_q[0];
    end else begin
      bus.wr_valid = 1'b0;
      bus.wr_data  = '0;
    end
    if ((ret_due.size() != 0) && (ret_due[0] <= cyc)) begin
      bus.sram_rvalid = 1'b1;
      bus.sram_rdata  = ret_data.pop_front();
      void'(ret_due.pop_front());
    end else begin
      bus.sram_rvalid = 1'b0;
      bus.sram_rdata  = '0;
    end
  end

  // Monitor on the falling edge: every handshake seen here completes on the
  // next rising edge. Checks addresses, data, exclusivity of re/we and that
  // words issued but not yet consumed never exceed the buffer depth.
  always @(negedge clk) begin
    int due;
    cyc++;
    if (!rst) begin
      checkOutput("re_we_exclusive", DW'(bus.sram_re & bus.sram_we), DW'(0));
      if (bus.sram_re || bus.sram_we) act_cnt++;
      if (bus.cmd_valid && bus.cmd_ready) cmd_cyc = cyc;
      if (bus.sram_re && bus.sram_ready) begin
        rd_acc++;
        inflight++;
        checkOutput("rd_addr_expected", DW'(exp_rd_addr.size() != 0), DW'(1));
        if (exp_rd_addr.size() != 0) begin
          checkOutput("rd_addr", DW'(bus.sram_addr), DW'(exp_rd_addr.pop_front()));
        end
        due = cyc + ((lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 5))) - 1;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        ret_due.push_back(due);
        ret_data.push_back(mem_read(bus.sram_addr));
      end
      if (bus.sram_we && bus.sram_ready) begin
        last_xfer_cyc = cyc;
        checkOutput("wr_expected", DW'(exp_wr_addr.size() != 0), DW'(1));
        if (exp_wr_addr.size() != 0) begin
          checkOutput("wr_addr", DW'(bus.sram_addr), DW'(exp_wr_addr.pop_front()));
          checkOutput("wr_data", bus.sram_wdata, exp_wr_data.pop_front());
        end
        sram_mem[int'(bus.sram_addr)] = bus.sram_wdata;
        if (st_q.size() != 0) void'(st_q.pop_front());
      end
      if (bus.rd_valid && bus.rd_ready) begin
        last_xfer_cyc = cyc;
        inflight--;
        checkOutput("pop_expected", DW'(exp_rd_data.size() != 0), DW'(1));
        if (exp_rd_data.size() != 0) begin
          checkOutput("rd_data", bus.rd_data, exp_rd_data.pop_front());
        end
      end
      checkOutput("fifo_credit", DW'(inflight <= DEPTH), DW'(1));
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Builds the expected transfer list for one command and presents it for
  // exactly one cycle; the engine must be idle when this is called.
  task automatic applyStimulus(input bit is_store, input logic [AW-1:0] addr, input int len);
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    for (int i = 0; i < len; i++) begin
      a = addr + AW'(i);
      if (is_store) begin
        w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        st_q.push_back(w);
        exp_wr_addr.push_back(a);
        exp_wr_data.push_back(w);
      end else begin
        exp_rd_addr.push_back(a);
        exp_rd_data.push_back(mem_read(a));
      end
    end
    done_base = done_cnt;
    rd_base = rd_acc;
    @(posedge clk);
    #1;
    checkOutput("cmd_ready_idle", DW'(bus.cmd_ready), DW'(1));
    bus.cmd_valid    = 1'b1;
    bus.cmd_is_store = is_store;
    bus.cmd_addr     = addr;
    bus.cmd_len      = LW'(len);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Bounded wait for completion, then checks the pulse count, its timing
  // and that every expected transfer was seen.
  task automatic waitDone(input int len);
    int n;
    n = 0;
    while ((done_cnt == done_base) && (n < 2000)) begin
      @(posedge clk);
      n++;
    end
    checkOutput("done_within_bound", DW'(n < 2000), DW'(1));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_once", DW'(done_cnt - done_base), DW'(1));
    if (len == 0) checkOutput("done_latency_len0", DW'(done_cyc), DW'(cmd_cyc + 1));
    else checkOutput("done_latency", DW'(done_cyc), DW'(last_xfer_cyc + 1));
    checkOutput("scoreboard_empty", DW'(exp_rd_data.size() + exp_wr_data.size() + exp_rd_addr.size()), DW'(0));
    checkOutput("busy_after_done", DW'(bus.busy), DW'(0));
  endtask

  initial begin
    int n;
    int a0;
    logic [AW-1:0] raddr;
    bit st;
    int len;

    rst              = 1'b1;
    bus.cmd_valid    = 1'b0;
    bus.cmd_is_store = 1'b0;
    bus.cmd_addr     = '0;
    bus.cmd_len      = '0;
    bus.rd_ready     = 1'b0;
    bus.wr_valid     = 1'b0;
    bus.wr_data      = '0;
    bus.sram_ready   = 1'b0;
    bus.sram_rdata   = '0;
    bus.sram_rvalid  = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_rd_valid", DW'(bus.rd_valid), DW'(0));
    checkOutput("rst_sram_re", DW'(bus.sram_re), DW'(0));
    checkOutput("rst_sram_we", DW'(bus.sram_we), DW'(0));
    checkOutput("rst_wr_ready", DW'(bus.wr_ready), DW'(0));
    checkOutput("rst_busy", DW'(bus.busy), DW'(0));
    checkOutput("rst_done", DW'(bus.done), DW'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_cmd_ready", DW'(bus.cmd_ready), DW'(1));

    // Single-word load with two-cycle SRAM latency.
    ready_mode = 0; rdr_mode = 1; lat_fixed = 2;
    sram_mem[32'h20] = DW'(32'hDEAD_BEEF);
    applyStimulus(1'b0, AW'(32'h00020), 1);
    waitDone(1);
    checkOutput("single_load_reads", DW'(rd_acc - rd_base), DW'(1));

    // Zero-length load and store.
    a0 = act_cnt;
    applyStimulus(1'b0, AW'(32'h00400), 0);
    checkOutput("len0_load_done", DW'(bus.done), DW'(1));
    checkOutput("len0_load_busy", DW'(bus.busy), DW'(1));
    waitDone(0);
    applyStimulus(1'b1, AW'(32'h00400), 0);
    checkOutput("len0_store_done", DW'(bus.done), DW'(1));
    waitDone(0);
    checkOutput("len0_no_sram_activity", DW'(act_cnt - a0), DW'(0));

    // Load of 8 with the VPU stalled: only DEPTH reads may go out.
    lat_fixed = 1; rdr_mode = 0;
    applyStimulus(1'b0, AW'(32'h00300), 8);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("stalled_reads_issued", DW'(rd_acc - rd_base), DW'(DEPTH));
    checkOutput("stalled_sram_re", DW'(bus.sram_re), DW'(0));
    checkOutput("stalled_rd_valid", DW'(bus.rd_valid), DW'(1));
    checkOutput("stalled_busy", DW'(bus.busy), DW'(1));
    rdr_mode = 1;
    waitDone(8);

    // Store wrapping past the top of the address space, SRAM ready toggling.
    ready_mode = 2; wv_mode = 1;
    applyStimulus(1'b1, AW'(32'hFFFFE), 4);
    waitDone(4);
    ready_mode = 0;
    applyStimulus(1'b0, AW'(32'hFFFFE), 4);
    waitDone(4);

    // Reset with two reads outstanding; late returns must be dropped.
    lat_fixed = 5; rdr_mode = 0;
    applyStimulus(1'b0, AW'(32'h00100), 2);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("pre_rst_outstanding_reads", DW'(rd_acc - rd_base), DW'(2));
    checkOutput("pre_rst_sram_re", DW'(bus.sram_re), DW'(0));
    rst = 1'b1;
    exp_rd_addr.delete();
    exp_rd_data.delete();
    inflight = 0;
    done_base = done_cnt;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rdr_mode = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("rd_valid_after_rst", DW'(bus.rd_valid), DW'(0));
    end
    n = 0;
    while ((ret_due.size() != 0) && (n < 100)) begin
      @(posedge clk);
      n++;
    end
    checkOutput("stale_returns_drained", DW'(ret_due.size()), DW'(0));
    checkOutput("no_done_after_rst", DW'(done_cnt - done_base), DW'(0));
    lat_fixed = 3;
    applyStimulus(1'b0, AW'(32'h00100), 2);
    waitDone(2);

    // Randomised commands and handshake behaviour.
    raddr = AW'(32'h00050);
    for (int k = 0; k < 30; k++) begin
      ready_mode = int'($urandom_range(0, 2));
      rdr_mode   = int'($urandom_range(1, 2));
      wv_mode    = int'($urandom_range(0, 1));
      lat_fixed  = 0;
      st         = ($urandom_range(1) == 1);
      len        = int'($urandom_range(0, 12));
      case ($urandom_range(0, 2))
        0:       raddr = AW'(32'hFFFFF - $urandom_range(0, 5));
        1:       raddr = raddr;
        default: raddr = AW'($urandom);
      endcase
      if (ready_mode == 2) bus.sram_ready = 1'b0;
      applyStimulus(st, raddr, len);
      waitDone(len);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #3000000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/vpu_sram_stream.md
VPU_SRAM_STREAM -- requirements
Module: vpu_sram_stream

Interface
REQ-001 Parameter DATA_W, default 256, width of SRAM word and stream data.
REQ-002 Parameter ADDR_W, default 20, SRAM word-address width.
REQ-003 Parameter LEN_W, default 16, burst length field width (words).
REQ-004 Parameter FIFO_DEPTH, default 4, read-return buffer depth (power of two, >=2).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 cmd_valid / cmd_ready  input / output  1 / 1  command handshake; transfer when both high.
REQ-008 cmd_is_store  input  1  0 = load (SRAM -> VPU), 1 = store (VPU -> SRAM).
REQ-009 cmd_addr / cmd_len  input  ADDR_W / LEN_W  start word address; word count.
REQ-010 rd_data / rd_valid / rd_ready  output / output / input  DATA_W / 1 / 1  load data stream to VPU.
REQ-011 wr_data / wr_valid / wr_ready  input / input / output  DATA_W / 1 / 1  store data stream from VPU.
REQ-012 sram_addr / sram_re / sram_we / sram_wdata  output  ADDR_W / 1 / 1 / DATA_W  SRAM request port.
REQ-013 sram_ready  input  1  SRAM accepts request this cycle when high.
REQ-014 sram_rdata / sram_rvalid  input  DATA_W / 1  read return; exactly one per accepted read, in order, latency >=1.
REQ-015 busy / done  output  1 / 1  command in progress; one-cycle completion pulse.

Function
REQ-016 States: IDLE, LOAD, STORE, DRAIN; cmd_ready SHALL be high only in IDLE.
REQ-017 IDLE + accepted command: latch addr into issue pointer, len into remaining count; go to LOAD or STORE per cmd_is_store.
REQ-018 cmd_len = 0: accepted, no SRAM request issued, done high the next cycle, return to IDLE.
REQ-019 LOAD: issue sram_re with sram_addr = pointer when remaining > 0 and (outstanding + fifo_count) < FIFO_DEPTH.
REQ-020 Read accepted (sram_re & sram_ready): pointer +1, remaining -1, outstanding +1; request held stable while sram_ready low.
REQ-021 sram_rvalid: push sram_rdata into FIFO, outstanding -1; same-cycle issue and return both counted correctly.
REQ-022 rd_valid = FIFO not empty; rd_data = FIFO head; pop on rd_valid & rd_ready; simultaneous push and pop at full allowed only per credit rule (never overflow).
REQ-023 LOAD -> DRAIN when remaining reaches 0; DRAIN -> IDLE with done pulse when outstanding = 0 and FIFO empty.
REQ-024 STORE: sram_we = wr_valid & remaining > 0; sram_wdata = wr_data; wr_ready = sram_ready & remaining > 0 (combinational pass-through, zero buffering).
REQ-025 Store accepted (wr_valid & sram_ready): pointer +1, remaining -1; at remaining 1 -> 0 go to IDLE with done pulse next cycle.
REQ-026 Pointer arithmetic modulo 2^ADDR_W; wrap from all-ones to 0 without error.
REQ-027 sram_re and sram_we SHALL never be high together; both low in IDLE and DRAIN.
REQ-028 sram_rvalid received in IDLE (outstanding = 0) SHALL be ignored.
REQ-029 busy = (state != IDLE) or done pending.

Reset
REQ-030 rst high: state IDLE, pointer/remaining/outstanding/FIFO pointers 0; cmd_ready 1 after release; rd_valid, sram_re, sram_we, wr_ready, busy, done 0.
REQ-031 rst mid-burst: in-flight reads discarded, FIFO flushed, no done pulse; later returns dropped per REQ-028.

Verification
REQ-032 Load addr 0x00020 len 1, SRAM latency 2, word 0xDEADBEEF -> one read at 0x00020, rd_data = 0xDEADBEEF, done 1 cycle after pop.
REQ-033 Load len 8, rd_ready held low -> exactly FIFO_DEPTH (4) reads issued, then sram_re low until pops; all 8 words delivered in address order.
REQ-034 Store addr 0xFFFFE len 4, sram_ready toggling -> writes to 0xFFFFE, 0xFFFFF, 0x00000, 0x00001 with matching data; done once.
REQ-035 cmd_len 0 load and store -> no sram_re/sram_we, done one cycle after acceptance.
REQ-036 rst asserted with 2 reads outstanding, then returns arrive -> rd_valid stays 0, no done, next load of len 2 returns correct data.
REQ-037 Random commands, random sram_ready/rd_ready/latency 1-5 -> scoreboard match, FIFO never overflows, re/we never simultaneous.
